// File: rtl/axis_bram_writer_pkg.sv
// Shared types and constants for the AXI-Stream to BRAM writer.
package axis_bram_writer_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RUN      = 3'd1;
   localparam logic [2:0] ST_WAIT_ACK = 3'd2;
   localparam logic [2:0] ST_DONE     = 3'd3;
   localparam logic [2:0] ST_ERR      = 3'd4;

   localparam int DEF_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      RUN      = ST_RUN,
      WAIT_ACK = ST_WAIT_ACK,
      DONE     = ST_DONE,
      ERR      = ST_ERR
   } wr_state_t;

   // What a written word means for the operation once its write has landed.
   typedef enum logic [1:0] {
      OUT_CONT = 2'd0,
      OUT_DONE = 2'd1,
      OUT_ERR  = 2'd2
   } wr_outcome_t;

   function automatic wr_state_t outcome_state(input wr_outcome_t oc);
      wr_state_t st;
      case (oc)
         OUT_DONE: st = DONE;
         OUT_ERR:  st = ERR;
         default:  st = RUN;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/axis_bram_writer_if.sv
// Input stream and BRAM write port bundle; slave is the writer side.
interface axis_bram_writer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int WE_WIDTH   = DATA_WIDTH/8
);
   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic                  s_axis_tlast;

   logic                  bram_en;
   logic [WE_WIDTH-1:0]   bram_we;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic [DATA_WIDTH-1:0] bram_wrdata;
   logic                  bram_wrack;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, bram_wrack,
      output s_axis_tready, bram_en, bram_we, bram_addr, bram_wrdata
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, bram_wrack,
      input  s_axis_tready, bram_en, bram_we, bram_addr, bram_wrdata
   );
endinterface

// File: rtl/bram_wr_addr_gen.sv
// Word counter plus base register producing the byte address of the next write.
module bram_wr_addr_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int ADDR_INCR  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic                  step,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH-1:0] addr
);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] INCR_VAL = ADDR_WIDTH'(ADDR_INCR);

   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         base_q <= base;
         cnt_q  <= '0;
      end else if (step) begin
         cnt_q  <= cnt_q + CNT_ONE;
      end
   end

   // Address wraps modulo 2^ADDR_WIDTH by truncation.
   assign addr  = base_q + cnt_q[ADDR_WIDTH-1:0] * INCR_VAL;
   assign count = cnt_q;

endmodule

// File: rtl/axis_bram_writer.sv
// Writes one AXI-Stream channel word-by-word into a BRAM port.
// Optional ack watchdog: define AXIS_BRAM_WRITER_ACK_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for operation_start
// RUN      | accepting stream beats (tready high)
// WAIT_ACK | write presented, holding until bram_wrack
// DONE     | one-cycle operation_complete pulse
// ERR      | one-cycle operation_error pulse
module axis_bram_writer
   import axis_bram_writer_pkg::*;
#(
   parameter int BRAM_ACK_SIG   = 1,
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 32,
   parameter int WE_WIDTH       = DATA_WIDTH/8,
   parameter int ADDR_INCR      = DATA_WIDTH/8,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  operation_start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   wr_size,
   output logic                  operation_busy,
   output logic                  operation_complete,
   output logic                  operation_error,
   axis_bram_writer_if.slave     bus
);
   localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

   wr_state_t             state_q, state_nx;
   wr_outcome_t           pend_q, pend_nx, beat_outcome;
   logic [ADDR_WIDTH:0]   size_q;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  load;
   logic                  beat;
   logic                  last_word;
   logic                  hold_wr;
   logic                  ack_timeout;

   logic                  en_q;
   logic [WE_WIDTH-1:0]   we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;

   bram_wr_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ADDR_INCR  (ADDR_INCR)
   ) u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .base  (base_addr),
      .step  (beat),
      .count (word_cnt),
      .addr  (next_addr)
   );

   assign beat      = (state_q == RUN) && bus.s_axis_tvalid;
   assign last_word = (word_cnt == size_q - CNT_ONE);

   // A mismatched tlast still writes its word; the error is raised afterwards.
   always_comb begin
      beat_outcome = OUT_CONT;
      if (last_word) begin
         if (bus.s_axis_tlast) beat_outcome = OUT_DONE;
         else                  beat_outcome = OUT_ERR;
      end else if (bus.s_axis_tlast) begin
         beat_outcome = OUT_ERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= OUT_CONT;
         size_q  <= '0;
      end else begin
         state_q <= state_nx;
         pend_q  <= pend_nx;
         if (load) size_q <= wr_size;
      end
   end

   always_comb begin
      state_nx = state_q;
      pend_nx  = pend_q;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (operation_start) begin
               load = 1'b1;
               if (wr_size == '0) state_nx = DONE;
               else               state_nx = RUN;
            end
         end
         RUN: begin
            if (beat) begin
               if (BRAM_ACK_SIG != 0) begin
                  state_nx = WAIT_ACK;
                  pend_nx  = beat_outcome;
               end else begin
                  state_nx = outcome_state(beat_outcome);
               end
            end
         end
         WAIT_ACK: begin
            if (bus.bram_wrack)   state_nx = outcome_state(pend_q);
            else if (ack_timeout) state_nx = ERR;
         end
         DONE:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef AXIS_BRAM_WRITER_ACK_TIMEOUT_EN
   localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE  = 1;

   logic [TO_W-1:0] to_cnt_q;

   // Reloaded outside WAIT_ACK so every entry starts a full window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    to_cnt_q <= '0;
      else if (state_q != WAIT_ACK)  to_cnt_q <= TO_LOAD;
      else if (to_cnt_q != '0)       to_cnt_q <= to_cnt_q - TO_ONE;
   end

   assign ack_timeout = (BRAM_ACK_SIG != 0) && (state_q == WAIT_ACK) && (to_cnt_q == '0);
`else
   assign ack_timeout = 1'b0;
`endif

   assign hold_wr = (state_q == WAIT_ACK) && (state_nx == WAIT_ACK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= 1'b0;
         we_q   <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else if (beat) begin
         en_q   <= 1'b1;
         we_q   <= '1;
         addr_q <= next_addr;
         data_q <= bus.s_axis_tdata;
      end else if (!hold_wr) begin
         en_q   <= 1'b0;
         we_q   <= '0;
      end
   end

   assign bus.s_axis_tready  = (state_q == RUN);
   assign bus.bram_en        = en_q;
   assign bus.bram_we        = we_q;
   assign bus.bram_addr      = addr_q;
   assign bus.bram_wrdata    = data_q;

   assign operation_busy     = (state_q != IDLE);
   assign operation_complete = (state_q == DONE);
   assign operation_error    = (state_q == ERR);

endmodule

// File: tb/tb_axis_bram_writer.sv
// Scoreboard bench: one no-ack writer (index 0) and one ack writer (index 1).
module tb_axis_bram_writer;
   localparam int DW = 16;
   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b1;

   logic          start [2];
   logic [AW-1:0] base  [2];
   logic [AW:0]   size  [2];
   logic          tvalid[2];
   logic          tlast [2];
   logic          wrack [2];
   logic [DW-1:0] tdata [2];

   logic          busy_o  [2];
   logic          cmp_o   [2];
   logic          err_o   [2];
   logic          tready_o[2];
   logic          en_o    [2];
   logic [1:0]    we_o    [2];
   logic [AW-1:0] addr_o  [2];
   logic [DW-1:0] wd_o    [2];

   axis_bram_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   axis_bram_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

   assign bus0.s_axis_tdata  = tdata[0];
   assign bus0.s_axis_tvalid = tvalid[0];
   assign bus0.s_axis_tlast  = tlast[0];
   assign bus0.bram_wrack    = wrack[0];
   assign tready_o[0]        = bus0.s_axis_tready;
   assign en_o[0]            = bus0.bram_en;
   assign we_o[0]            = bus0.bram_we;
   assign addr_o[0]          = bus0.bram_addr;
   assign wd_o[0]            = bus0.bram_wrdata;

   assign bus1.s_axis_tdata  = tdata[1];
   assign bus1.s_axis_tvalid = tvalid[1];
   assign bus1.s_axis_tlast  = tlast[1];
   assign bus1.bram_wrack    = wrack[1];
   assign tready_o[1]        = bus1.s_axis_tready;
   assign en_o[1]            = bus1.bram_en;
   assign we_o[1]            = bus1.bram_we;
   assign addr_o[1]          = bus1.bram_addr;
   assign wd_o[1]            = bus1.bram_wrdata;

   axis_bram_writer #(
      .BRAM_ACK_SIG(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
   ) u_dut_noack (
      .clk(clk), .rst_n(rst_n), .operation_start(start[0]), .base_addr(base[0]),
      .wr_size(size[0]), .operation_busy(busy_o[0]), .operation_complete(cmp_o[0]),
      .operation_error(err_o[0]), .bus(bus0)
   );

   axis_bram_writer #(
      .BRAM_ACK_SIG(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
   ) u_dut_ack (
      .clk(clk), .rst_n(rst_n), .operation_start(start[1]), .base_addr(base[1]),
      .wr_size(size[1]), .operation_busy(busy_o[1]), .operation_complete(cmp_o[1]),
      .operation_error(err_o[1]), .bus(bus1)
   );

   int chk_cnt = 0;
   int fail_cnt = 0;
   int cyc = 0;
   int n_en[2], n_wr[2], n_cmp[2], n_perr[2];
   int first_en[2], last_wr[2], cmp_cyc[2], perr_cyc[2];
   logic prev_pulse[2];
   logic [AW+DW-1:0] sb0[$];
   logic [AW+DW-1:0] sb1[$];
   logic [AW-1:0] op_base[2];
   int op_idx[2];
   int ack_dly_q[$];
   bit ack_off = 1'b0;
   int ack_wait = 0;
   int cur_dly = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int sb_size(input int d);
      return (d == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic logic [AW+DW-1:0] sb_front(input int d);
      return (d == 0) ? sb0[0] : sb1[0];
   endfunction

   task automatic sb_push(input int d, input logic [AW+DW-1:0] w);
      if (d == 0) sb0.push_back(w);
      else        sb1.push_back(w);
   endtask

   task automatic sb_pop(input int d);
      if (d == 0) void'(sb0.pop_front());
      else        void'(sb1.pop_front());
   endtask

   always @(posedge clk) cyc++;

   // Monitor: every enabled cycle must match the oldest outstanding write.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [AW+DW-1:0] exp_w;
         if (prev_pulse[d]) check_eq("busy_after_pulse", busy_o[d], 0);
         prev_pulse[d] = cmp_o[d] | err_o[d];
         if (cmp_o[d]) begin n_cmp[d]++;  cmp_cyc[d]  = cyc; end
         if (err_o[d]) begin n_perr[d]++; perr_cyc[d] = cyc; end
         if (en_o[d]) begin
            n_en[d]++;
            if (first_en[d] < 0) first_en[d] = cyc;
            if (d == 1) check_eq("tready_low_in_wait_ack", tready_o[d], 0);
            check_eq("write_expected", sb_size(d) > 0, 1);
            if (sb_size(d) > 0) begin
               exp_w = sb_front(d);
               check_eq("bram_addr", addr_o[d], exp_w[AW+DW-1:DW]);
               check_eq("bram_wrdata", wd_o[d], exp_w[DW-1:0]);
               check_eq("bram_we", we_o[d], 2'b11);
               if (d == 0 || wrack[d]) begin
                  sb_pop(d);
                  n_wr[d]++;
                  last_wr[d] = cyc;
               end
            end
         end
      end
   end

   // Ack responder for the ack writer, delay per write taken from ack_dly_q.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (en_o[1] && !ack_off) begin
            if (ack_wait == 0) cur_dly = (ack_dly_q.size() > 0) ? ack_dly_q.pop_front() : 0;
            wrack[1] = (ack_wait == cur_dly);
            ack_wait++;
         end else begin
            wrack[1] = 1'b0;
            ack_wait = 0;
         end
      end
   end

   task automatic clr(input int d);
      n_en[d] = 0; n_wr[d] = 0; n_cmp[d] = 0; n_perr[d] = 0;
      first_en[d] = -1; last_wr[d] = -1; cmp_cyc[d] = -1; perr_cyc[d] = -1;
   endtask

   task automatic do_start(input int d, input logic [AW-1:0] b, input int n,
                           input bit accept, output int st_cyc);
      start[d] = 1'b1;
      base[d]  = b;
      size[d]  = '0;
      size[d][31:0] = n;
      if (accept) begin
         op_base[d] = b;
         op_idx[d]  = 0;
      end
      @(negedge clk);
      st_cyc = cyc;
      @(posedge clk); #1;
      start[d] = 1'b0;
   endtask

   task automatic send(input int d, input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         int k;
         k = 0;
         tvalid[d] = 1'b1;
         tdata[d]  = DW'($urandom);
         tlast[d]  = (i == last_at);
         do begin
            @(negedge clk);
            k++;
         end while (!tready_o[d] && k < 100);
         check_eq("tready_wait", tready_o[d], 1);
         if (tready_o[d]) begin
            sb_push(d, {op_base[d] + AW'(op_idx[d] * 2), tdata[d]});
            op_idx[d]++;
         end
         @(posedge clk); #1;
      end
      tvalid[d] = 1'b0;
      tlast[d]  = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int k = 0;
      while (busy_o[d] && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_eq("idle_in_time", busy_o[d], 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_outs_zero(input int d);
      check_eq("zero_tready", tready_o[d], 0);
      check_eq("zero_bram_en", en_o[d], 0);
      check_eq("zero_bram_we", we_o[d], 0);
      check_eq("zero_bram_addr", addr_o[d], 0);
      check_eq("zero_bram_wrdata", wd_o[d], 0);
      check_eq("zero_busy", busy_o[d], 0);
      check_eq("zero_complete", cmp_o[d], 0);
      check_eq("zero_error", err_o[d], 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int st, st_dummy;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; base[d] = '0; size[d] = '0; tvalid[d] = 1'b0;
         tlast[d] = 1'b0; wrack[d] = 1'b0; tdata[d] = '0; prev_pulse[d] = 1'b0;
         op_base[d] = '0; op_idx[d] = 0;
         clr(d);
      end
      #1 rst_n = 1'b0;
      #11;
      chk_outs_zero(0);
      chk_outs_zero(1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // No-ack writer: 4 back-to-back words
      clr(0);
      do_start(0, 32'h100, 4, 1'b1, st);
      send(0, 4, 3);
      wait_idle(0);
      check_eq("t1_writes", n_wr[0], 4);
      check_eq("t1_en_cycles", n_en[0], 4);
      check_eq("t1_back_to_back", last_wr[0] - first_en[0], 3);
      check_eq("t1_complete_count", n_cmp[0], 1);
      check_eq("t1_complete_with_last_write", cmp_cyc[0], last_wr[0]);
      check_eq("t1_no_error", n_perr[0], 0);
      check_eq("t1_sb_empty", sb_size(0), 0);

      // Ack writer: acks after 0, 2, 5 cycles
      ack_dly_q.push_back(0);
      ack_dly_q.push_back(2);
      ack_dly_q.push_back(5);
      clr(1);
      do_start(1, 32'h2000, 3, 1'b1, st);
      send(1, 3, 2);
      wait_idle(1);
      check_eq("t2_writes", n_wr[1], 3);
      check_eq("t2_en_cycles", n_en[1], 10);
      check_eq("t2_complete_count", n_cmp[1], 1);
      check_eq("t2_complete_after_ack", cmp_cyc[1], last_wr[1] + 1);
      check_eq("t2_no_error", n_perr[1], 0);
      check_eq("t2_sb_empty", sb_size(1), 0);

      for (int d = 0; d < 2; d++) begin
         // Early tlast, then a clean single-word operation
         clr(d);
         do_start(d, 32'h400 + 32'(d * 32'h1000), 4, 1'b1, st);
         send(d, 2, 1);
         wait_idle(d);
         check_eq("t3_writes", n_wr[d], 2);
         check_eq("t3_error_count", n_perr[d], 1);
         check_eq("t3_no_complete", n_cmp[d], 0);
         check_eq("t3_error_timing", perr_cyc[d], last_wr[d] + d);
         clr(d);
         do_start(d, 32'h500, 1, 1'b1, st);
         send(d, 1, 0);
         wait_idle(d);
         check_eq("t3_retry_writes", n_wr[d], 1);
         check_eq("t3_retry_complete", n_cmp[d], 1);
         check_eq("t3_retry_no_error", n_perr[d], 0);

         // Missing tlast on the final word, with address wrap
         clr(d);
         do_start(d, 32'hFFFF_FFFE, 2, 1'b1, st);
         send(d, 2, -1);
         wait_idle(d);
         check_eq("t4_writes", n_wr[d], 2);
         check_eq("t4_error_count", n_perr[d], 1);
         check_eq("t4_no_complete", n_cmp[d], 0);
         check_eq("t4_error_timing", perr_cyc[d], last_wr[d] + d);

         // Zero-size start, then a start during the DONE cycle
         clr(d);
         do_start(d, 32'h600, 0, 1'b1, st);
         do_start(d, 32'h680, 5, 1'b0, st_dummy);
         wait_idle(d);
         repeat (8) @(posedge clk);
         #1;
         check_eq("t5_no_bram_en", n_en[d], 0);
         check_eq("t5_complete_count", n_cmp[d], 1);
         check_eq("t5_complete_timing", cmp_cyc[d], st + 1);
         check_eq("t5_no_error", n_perr[d], 0);
         check_eq("t5_idle", busy_o[d], 0);
         check_eq("t5_sb_empty", sb_size(d), 0);
      end

`ifdef AXIS_BRAM_WRITER_ACK_TIMEOUT_EN
      // Ack withheld: watchdog ends the operation
      clr(1);
      ack_off = 1'b1;
      do_start(1, 32'h700, 2, 1'b1, st);
      send(1, 1, -1);
      wait_idle(1);
      check_eq("t6_en_cycles", n_en[1], 8);
      check_eq("t6_no_acked_write", n_wr[1], 0);
      check_eq("t6_error_count", n_perr[1], 1);
      check_eq("t6_no_complete", n_cmp[1], 0);
      check_eq("t6_error_timing", perr_cyc[1], first_en[1] + 8);
      check_eq("t6_pending_word", sb_size(1), 1);
      sb1.delete();
      ack_off = 1'b0;
`endif

      // Reset in the middle of a run
      clr(0);
      do_start(0, 32'h800, 4, 1'b1, st);
      send(0, 2, -1);
      @(negedge clk);
      #2;
      tvalid[0] = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_outs_zero(0);
      repeat (2) @(posedge clk);
      #1;
      tvalid[0] = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("t7_writes_before_reset", n_wr[0], 2);
      check_eq("t7_no_complete", n_cmp[0], 0);
      check_eq("t7_no_error", n_perr[0], 0);
      check_eq("t7_idle", busy_o[0], 0);
      check_eq("t7_sb_empty", sb_size(0), 0);

      clr(0);
      do_start(0, 32'h900, 1, 1'b1, st);
      send(0, 1, 0);
      wait_idle(0);
      check_eq("t7_recover_writes", n_wr[0], 1);
      check_eq("t7_recover_complete", n_cmp[0], 1);

      $display("Result: errors=%0d of %0d checks", fail_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/axis_bram_writer.md
Name: axis_bram_writer

Overview:
- Write-side counterpart of the memory control unit: accepts one AXI-Stream result channel and writes it word-by-word into a BRAM through a BRAM-controller port.
- Control and interrupt interface has the same shape as the MCU's: start, size, busy, complete, error.
- Sits at the processor output, one instance per result stream.
- Single clock domain; write-only.

Parameters:
- BRAM_ACK_SIG, 1: BRAM port returns a write ack. When 0, each write is a one-cycle fire-and-forget pulse.
- DATA_WIDTH, 16: stream and BRAM data width in bits; multiple of 8.
- ADDR_WIDTH, 32: BRAM address width in bits.
- WE_WIDTH, DATA_WIDTH/8: byte-enable width.
- ADDR_INCR, DATA_WIDTH/8: address step per word, in bytes.
- TIMEOUT_CYCLES, 1024: ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- operation_start  in  1  single-cycle start request.
- base_addr  in  ADDR_WIDTH  first write address; latched at start.
- wr_size  in  ADDR_WIDTH+1  number of words to write; latched at start.
- operation_busy  out  1  high while an operation is in progress.
- operation_complete  out  1  one-cycle pulse on successful completion.
- operation_error  out  1  one-cycle pulse on tlast mismatch or ack timeout.
- s_axis_tdata  in  DATA_WIDTH  input stream data.
- s_axis_tvalid  in  1  input stream valid.
- s_axis_tready  out  1  input stream ready.
- s_axis_tlast  in  1  input stream last-beat marker.
- bram_en  out  1  BRAM enable.
- bram_we  out  WE_WIDTH  BRAM byte write enables.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_wrdata  out  DATA_WIDTH  BRAM write data.
- bram_wrack  in  1  write ack; ignored when BRAM_ACK_SIG=0.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; every output 0; counters 0.
- States: IDLE, RUN, WAIT_ACK, DONE, ERR.
- IDLE:
  - operation_start=1 latches base_addr and wr_size and clears the word count.
  - wr_size=0 goes to DONE; otherwise goes to RUN.
- RUN:
  - s_axis_tready=1, decoded combinationally from state == RUN only.
  - On a beat (tvalid & tready), the next cycle drives bram_en=1, bram_we=all ones, bram_addr=base+count*ADDR_INCR (mod 2^ADDR_WIDTH, wrap silently), bram_wrdata=tdata. The count then increments.
  - BRAM outputs are registered: latency from beat to bram_en is 1 cycle.
  - bram_en and bram_we fall to 0 in any cycle with no new write.
- BRAM_ACK_SIG=1:
  - Every beat moves the FSM to WAIT_ACK, so tready=0 there.
  - bram_en, we, addr and wrdata hold until bram_wrack=1 is sampled.
  - On ack: go to RUN, or to DONE/ERR if this was the final word. Sustained rate is at most 1 word per 2 cycles.
- BRAM_ACK_SIG=0: back-to-back beats give back-to-back writes, 1 word per cycle.
- Final word is the beat where count == wr_size-1.
  - tlast=1: DONE.
  - tlast=0: ERR. The word is still written.
- Early tlast (tlast=1 with count < wr_size-1): the word is written, then ERR. Remaining words are not requested.
- DONE: operation_complete=1 for exactly one cycle, then IDLE.
  - No-ack case: the complete pulse coincides with the final bram_en cycle.
  - Ack case: the complete pulse comes the cycle after bram_wrack is sampled.
- ERR: operation_error=1 for one cycle, then IDLE. Words already written are not rolled back.
- operation_busy=1 in RUN, WAIT_ACK, DONE and ERR; 0 in IDLE.
- operation_start while busy is ignored.
- A start in the same cycle as the DONE/ERR pulse is ignored; a start is accepted only in IDLE.
- Reset asserted mid-operation aborts immediately:
  - No complete or error pulse.
  - tready drops asynchronously.
- bram_wrack when not in WAIT_ACK is ignored.

Optional Feature:
- Macro: AXIS_BRAM_WRITER_ACK_TIMEOUT_EN; effective only with BRAM_ACK_SIG=1.
- Defined:
  - A cycle counter runs in WAIT_ACK and clears on each entry.
  - When it reaches TIMEOUT_CYCLES with no ack, the FSM drops bram_en/we and goes to ERR.
- Undefined: WAIT_ACK waits indefinitely; no counter logic is synthesized.

Decomposition:
- Shared package axis_bram_writer_pkg:
  - FSM state typedef: IDLE, RUN, WAIT_ACK, DONE, ERR.
  - Encoding constants for those states.
  - Default TIMEOUT_CYCLES.
- Sub-module bram_wr_addr_gen: latches base and count and produces bram_addr. It is reusable by any future multi-channel writer.
- Everything else stays in the single FSM module.

Test Plan:
- BRAM_ACK_SIG=0, base=0x100, size=4, 4 beats with tvalid held high, tlast on the 4th → addr 0x100, 0x102, 0x104, 0x106 on 4 consecutive bram_en cycles. operation_complete pulses with the 4th write; busy low the following cycle.
- BRAM_ACK_SIG=1, size=3, ack delayed 0, 2 and 5 cycles → tready low for the whole of each WAIT_ACK. Exactly 3 writes occur, each held stable until its ack. Complete pulses 1 cycle after the 3rd ack.
- size=4, tlast on beat 2 → 2 writes, operation_error pulses once, no complete. A following start with size=1 succeeds.
- size=2, no tlast on beat 2 → 2 writes, then an error pulse.
- size=0 start → no bram_en. Complete pulses 1 cycle after start. A start issued while busy is ignored.
- With AXIS_BRAM_WRITER_ACK_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack withheld → error pulse after 8 WAIT_ACK cycles and bram_en drops. Separately, rst_n pulsed low mid-RUN → all outputs 0 immediately and no pulses.
